// File: rtl/priority_encoder32.sv
// Registered priority encoder: reports the index of the highest set bit of the
// request vector, with a valid flag that separates "bit 0 set" from "nothing
// requested / disabled". One cycle latency, no combinational input-to-output path.
module priority_encoder32 #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] A,
  output logic [IDX_W-1:0] Y,
  output logic             valid
);

  logic [IDX_W-1:0] idx_tree;
  logic             any_req;
  logic [IDX_W-1:0] y_d, y_q;
  logic             valid_d, valid_q;

  // Log-tree search: at each level keep the upper half of the current window
  // when it holds any set bit (and record that choice as one index bit),
  // otherwise fall back to the lower half.
  always_comb begin
    logic [WIDTH-1:0] win;
    logic [WIDTH-1:0] upper;
    logic [WIDTH-1:0] lo_mask;
    idx_tree = '0;
    win      = A;
    upper    = '0;
    lo_mask  = '0;
    for (int l = int'(IDX_W) - 1; l >= 0; l--) begin
      lo_mask = (WIDTH'(1) << (1 << l)) - WIDTH'(1);
      upper   = (win >> (1 << l)) & lo_mask;
      if (|upper) begin
        idx_tree[l] = 1'b1;
        win         = upper;
      end else begin
        win = win & lo_mask;
      end
    end
  end

  // Gate the tree result: disabled or empty requests encode as 0 / not valid.
  always_comb begin
    any_req = |A;
    valid_d = en & any_req;
    y_d     = valid_d ? idx_tree : '0;
  end

  // Output stage; reset wins over enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  assign Y     = y_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_priority_encoder32.sv
// Directed and random checks for the registered 32-to-5 priority encoder.
module tb_priority_encoder32;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] A;
  logic [4:0]  Y;
  logic        valid;

  int n_tests = 0;
  int n_fail  = 0;

  priority_encoder32 dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .A     (A),
    .Y     (Y),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Apply inputs, clock once, then sample 1 time unit after the edge.
  task automatic step(input logic r, input logic e, input logic [31:0] a);
    rst = r;
    en  = e;
    A   = a;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input int y_exp, input logic v_exp);
    check({tag, ".Y"}, 32'(Y), 32'(y_exp));
    check({tag, ".valid"}, 32'(valid), 32'(v_exp));
  endtask

  // Reference: plain LSB-to-MSB scan, last hit wins.
  function automatic logic [5:0] ref_out(input logic r, input logic e, input logic [31:0] a);
    logic [4:0] idx;
    idx = '0;
    if (r || !e || a == 32'd0) return 6'd0;
    for (int i = 0; i < 32; i++) begin
      if (a[i]) idx = 5'(i);
    end
    return {1'b1, idx};
  endfunction

  initial begin
    logic        r_rand;
    logic        e_rand;
    logic [31:0] a_rand;

    rst = 1'b1;
    en  = 1'b0;
    A   = '0;
    @(negedge clk);

    // Reset holds outputs at 0/0 even with a full request vector enabled.
    step(1'b1, 1'b1, 32'hFFFF_FFFF);
    expect_out("reset_c1", 0, 1'b0);
    step(1'b1, 1'b1, 32'hFFFF_FFFF);
    expect_out("reset_c2", 0, 1'b0);
    step(1'b0, 1'b1, 32'hFFFF_FFFF);
    expect_out("reset_release", 31, 1'b1);

    // Low end of the index range.
    step(1'b0, 1'b1, 32'h0000_0000);
    expect_out("zero", 0, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0001);
    expect_out("bit0", 0, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0003);
    expect_out("bits1_0", 1, 1'b1);
    step(1'b0, 1'b1, 32'h0000_000F);
    expect_out("nibble", 3, 1'b1);

    // Enable gating, then re-enable with the same vector.
    step(1'b0, 1'b0, 32'h0000_0004);
    expect_out("en_off", 0, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0004);
    expect_out("en_on", 2, 1'b1);

    // Multi-hot: only the highest set bit matters.
    step(1'b0, 1'b1, 32'h0004_005F);
    expect_out("multi_b18", 18, 1'b1);
    step(1'b0, 1'b1, 32'h8000_0001);
    expect_out("multi_b31", 31, 1'b1);

    // Mid-stream reset gives 0/0, next cycle resumes from fresh inputs.
    step(1'b1, 1'b1, 32'h0000_0100);
    expect_out("mid_reset", 0, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0100);
    expect_out("after_reset", 8, 1'b1);

    // Walking one across every position.
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 1'b1, 32'd1 << i);
      expect_out($sformatf("walk%0d", i), i, 1'b1);
    end

    // Random vectors; shifting spreads the top set bit over all positions.
    for (int k = 0; k < 1000; k++) begin
      r_rand = ($urandom_range(0, 99) < 5);
      e_rand = ($urandom_range(0, 3) != 0);
      a_rand = $urandom() >> $urandom_range(0, 31);
      if ($urandom_range(0, 19) == 0) a_rand = '0;
      step(r_rand, e_rand, a_rand);
      check($sformatf("rand%0d", k), 32'({valid, Y}), 32'(ref_out(r_rand, e_rand, a_rand)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
